regfile_mp_sb: RTL and testbench

Parametrised multi-port integer register file for the RV32IC core with hardwired-zero x0, priority-resolved multiple write ports, optional same-cycle write-to-read bypass and a per-register busy scoreboard. It sits between decode/issue, which reads operands and marks destinations busy, and writeback, which writes results and clears busy. It replaces the single-port register file and adds hazard tracking for pipelined and multi-issue operation.

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/regfile_mp_sb_if.sv | 31 +++
 rtl/regfile_mp_sb_scoreboard.sv | 56 +++++
 rtl/regfile_mp_sb.sv | 98 +++++++++
 tb/tb_regfile_mp_sb.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port integer register file: defaults,
// address-width helper and the write-port priority selector.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREG_DEF  = 32;
    localparam int unsigned ZERO_ADDR = 0;

    // Upper bound on write ports handled by the priority selector
    localparam int unsigned MAX_WR = 8;
    localparam int unsigned WSEL_W = 3;

    typedef struct packed {
        logic              hit;
        logic [WSEL_W-1:0] idx;
    } wsel_t;

    function automatic int unsigned addr_w(input int unsigned n);
        return (n <= 2) ? 1 : unsigned'($clog2(n));
    endfunction

    // Highest-indexed asserted hit wins
    function automatic wsel_t wr_select(input logic [MAX_WR-1:0] hits);
        wsel_t s;
        s = '0;
        for (int i = 0; i < MAX_WR; i++) begin
            if (hits[i]) begin
                s.hit = 1'b1;
                s.idx = WSEL_W'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Operand read, writeback and issue/flush signals between the pipeline and
// the register file.
interface regfile_mp_sb_if
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned AW   = 5,
    parameter int unsigned NRD  = 2,
    parameter int unsigned NWR  = 1
);
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, flush clears all,
// plus a registered population count.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned AW       = 5,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_eff,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREG-1:0]   busy,
    output logic [NREG-1:0]   clr_c,
    output logic [NREG-1:0]   set_c,
    output logic [AW:0]       busy_cnt
);
    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0] busy_nxt_c;
    logic [CW-1:0]   cnt_nxt_c;

    // Decode this cycle's set and clear requests
    always_comb begin
        clr_c = '0;
        set_c = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_eff[w]) clr_c[wr_addr[w*AW +: AW]] = 1'b1;
        end
        if (iss_en && !(ZERO_REG != 0 && iss_addr == AW'(ZERO_ADDR)))
            set_c[iss_addr] = 1'b1;
    end

    // Flush beats issue; issue beats writeback clear of the same register
    always_comb begin
        busy_nxt_c = flush ? '0 : ((busy & ~clr_c) | set_c);
        cnt_nxt_c  = '0;
        for (int r = 0; r < NREG; r++) cnt_nxt_c = cnt_nxt_c + CW'(busy_nxt_c[r]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt_c;
            busy_cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with hardwired x0, prioritised writes,
// optional write-to-read bypass and a busy scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREG     = NREG_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
)(
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave bus
);
    localparam int unsigned AW = addr_w(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NWR-1:0]  wr_eff_c;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr_c;
    logic [NREG-1:0] set_c;

    // Writes to x0 are dropped everywhere, including bypass and scoreboard
    always_comb begin
        wr_eff_c = '0;
        for (int w = 0; w < NWR; w++) begin
            wr_eff_c[w] = bus.wr_en[w] &&
                          !(ZERO_REG != 0 && bus.wr_addr[w*AW +: AW] == AW'(ZERO_ADDR));
        end
    end

    // Later ports overwrite earlier ones, so the highest index wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (wr_eff_c[w]) regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
            end
        end
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .wr_eff   (wr_eff_c),
        .wr_addr  (bus.wr_addr),
        .busy     (busy),
        .clr_c    (clr_c),
        .set_c    (set_c),
        .busy_cnt (bus.busy_cnt)
    );

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]     addr_c;
        logic [MAX_WR-1:0] hits_c;
        wsel_t             sel_c;
        logic [XLEN-1:0]   fwd_c;
        logic              is_zero_c;
        logic              use_fwd_c;

        assign addr_c    = bus.rd_addr[p*AW +: AW];
        assign is_zero_c = (ZERO_REG != 0) && (addr_c == AW'(ZERO_ADDR));

        // Pick the highest-indexed same-cycle write to this address
        always_comb begin
            hits_c = '0;
            fwd_c  = '0;
            for (int w = 0; w < NWR; w++) begin
                hits_c[w] = wr_eff_c[w] && (bus.wr_addr[w*AW +: AW] == addr_c);
            end
            sel_c = wr_select(hits_c);
            for (int w = 0; w < NWR; w++) begin
                if (sel_c.idx == WSEL_W'(w)) fwd_c = bus.wr_data[w*XLEN +: XLEN];
            end
        end

        // Writes during reset are lost, so they must not be forwarded either
        assign use_fwd_c = (BYPASS != 0) && !rst && sel_c.hit;

        assign bus.rd_data[p*XLEN +: XLEN] = is_zero_c ? '0 :
                                             use_fwd_c ? fwd_c : regs[addr_c];

        assign bus.rd_busy[p] = busy[addr_c] &&
                                !((BYPASS != 0) && clr_c[addr_c] && !set_c[addr_c]);
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: a bypassing two-write-port instance and a non-bypassing
// single-write-port instance share stimulus and are checked against a model.
module tb_regfile_mp_sb;
    import regfile_pkg::*;

    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [31:0] a0, a1, b0, b1;
        logic        k0, k1;
        logic [5:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wen;
    logic [4:0]  wad [2];
    logic [31:0] wdt [2];
    logic        iss;
    logic [4:0]  issa;
    logic        flsh;
    logic [4:0]  ra  [2];

    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [31:0] mbusy;
    exp_t        q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.XLEN(32), .AW(AW), .NRD(2), .NWR(2)) ifa ();
    regfile_mp_sb_if #(.XLEN(32), .AW(AW), .NRD(2), .NWR(1)) ifb ();

    assign ifa.rd_addr  = {ra[1], ra[0]};
    assign ifa.wr_en    = wen;
    assign ifa.wr_addr  = {wad[1], wad[0]};
    assign ifa.wr_data  = {wdt[1], wdt[0]};
    assign ifa.iss_en   = iss;
    assign ifa.iss_addr = issa;
    assign ifa.flush    = flsh;

    assign ifb.rd_addr  = {ra[1], ra[0]};
    assign ifb.wr_en    = wen[0:0];
    assign ifb.wr_addr  = wad[0];
    assign ifb.wr_data  = wdt[0];
    assign ifb.iss_en   = iss;
    assign ifb.iss_addr = issa;
    assign ifb.flush    = flsh;

    regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_mp_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_a_data(input logic [4:0] a);
        logic [31:0] d;
        if (rst || a == 5'd0) return 32'd0;
        d = ma[a];
        for (int w = 0; w < 2; w++) if (wen[w] && wad[w] == a) d = wdt[w];
        return d;
    endfunction

    function automatic logic [31:0] exp_b_data(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'd0;
        return mb[a];
    endfunction

    function automatic logic exp_a_busy(input logic [4:0] a);
        logic clr, set;
        clr = 1'b0;
        for (int w = 0; w < 2; w++) if (wen[w] && wad[w] == a && a != 5'd0) clr = 1'b1;
        set = iss && issa == a && a != 5'd0;
        return mbusy[a] && !(clr && !set);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            ma[r] = '0;
            mb[r] = '0;
        end
        mbusy = '0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_clear();
            return;
        end
        for (int w = 0; w < 2; w++) if (wen[w] && wad[w] != 5'd0) ma[wad[w]] = wdt[w];
        if (wen[0] && wad[0] != 5'd0) mb[wad[0]] = wdt[0];
        if (flsh) mbusy = '0;
        else begin
            for (int w = 0; w < 2; w++) if (wen[w] && wad[w] != 5'd0) mbusy[wad[w]] = 1'b0;
            if (iss && issa != 5'd0) mbusy[issa] = 1'b1;
        end
    endtask

    task automatic idle();
        wen = '0; iss = 1'b0; issa = '0; flsh = 1'b0;
        for (int w = 0; w < 2; w++) begin
            wad[w] = '0;
            wdt[w] = '0;
        end
    endtask

    // Predict outputs for the current inputs, compare mid-cycle, then clock
    task automatic cycle();
        exp_t e;
        e.a0  = exp_a_data(ra[0]);
        e.a1  = exp_a_data(ra[1]);
        e.b0  = exp_b_data(ra[0]);
        e.b1  = exp_b_data(ra[1]);
        e.k0  = exp_a_busy(ra[0]);
        e.k1  = exp_a_busy(ra[1]);
        e.cnt = 6'($countones(mbusy));
        q.push_back(e);
        @(negedge clk);
        e = q.pop_front();
        check("a_rd0",   ifa.rd_data[31:0],  e.a0);
        check("a_rd1",   ifa.rd_data[63:32], e.a1);
        check("b_rd0",   ifb.rd_data[31:0],  e.b0);
        check("b_rd1",   ifb.rd_data[63:32], e.b1);
        check("a_busy0", 32'(ifa.rd_busy[0]), 32'(e.k0));
        check("a_busy1", 32'(ifa.rd_busy[1]), 32'(e.k1));
        check("a_cnt",   32'(ifa.busy_cnt),   32'(e.cnt));
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        ra[0] = '0; ra[1] = '0;

        // Reset: every address reads zero, with writes/issues lost
        for (int a = 0; a < 32; a++) begin
            ra[0] = 5'(a); ra[1] = 5'(31 - a);
            wen = 2'b01; wad[0] = 5'(a); wdt[0] = 32'hFFFF_0000 | 32'(a);
            iss = 1'b1; issa = 5'(a);
            cycle();
        end
        idle();
        rst = 1'b0;

        // x0 stays zero and never busy
        wen = 2'b01; wad[0] = 5'd0; wdt[0] = 32'hDEADBEEF; iss = 1'b1; issa = 5'd0;
        ra[0] = 5'd0; ra[1] = 5'd0;
        cycle();
        idle();
        cycle();

        // Bypass versus registered visibility
        wen = 2'b01; wad[0] = 5'd5; wdt[0] = 32'h12345678; ra[0] = 5'd5; ra[1] = 5'd5;
        cycle();
        idle();
        cycle();

        // Two writes to one register: higher port wins
        wen = 2'b11; wad[0] = 5'd7; wad[1] = 5'd7; wdt[0] = 32'h1; wdt[1] = 32'h2;
        ra[0] = 5'd7; ra[1] = 5'd5;
        cycle();
        idle();
        cycle();

        // Scoreboard set / simultaneous set+clear / clear
        ra[0] = 5'd3; ra[1] = 5'd7;
        iss = 1'b1; issa = 5'd3; cycle();
        idle(); cycle();
        wen = 2'b01; wad[0] = 5'd3; wdt[0] = 32'h33; iss = 1'b1; issa = 5'd3; cycle();
        idle(); cycle();
        wen = 2'b01; wad[0] = 5'd3; wdt[0] = 32'h34; cycle();
        idle(); cycle();

        // Flush wins over a same-cycle issue
        ra[0] = 5'd1; ra[1] = 5'd4;
        foreach (ra[i]) ;
        iss = 1'b1; issa = 5'd1; cycle();
        issa = 5'd2; cycle();
        issa = 5'd4; cycle();
        idle(); cycle();
        flsh = 1'b1; iss = 1'b1; issa = 5'd6; cycle();
        idle(); ra[0] = 5'd6; ra[1] = 5'd2; cycle();

        // Asynchronous reset between edges clears state immediately
        wen = 2'b01; wad[0] = 5'd9; wdt[0] = 32'hA5A5_5A5A; iss = 1'b1; issa = 5'd9; cycle();
        idle(); ra[0] = 5'd9; ra[1] = 5'd5; cycle();
        wen = 2'b10; wad[1] = 5'd10; wdt[1] = 32'h0BAD_F00D; iss = 1'b1; issa = 5'd10;
        ra[0] = 5'd9; ra[1] = 5'd10;
        #1 rst = 1'b1;
        model_clear();
        cycle();
        rst = 1'b0;
        idle(); cycle();

        // Random traffic over a small address window to provoke collisions
        for (int n = 0; n < 300; n++) begin
            wen    = 2'($urandom_range(0, 3));
            wad[0] = 5'($urandom_range(0, 7));
            wad[1] = 5'($urandom_range(0, 7));
            wdt[0] = $urandom;
            wdt[1] = $urandom;
            iss    = 1'($urandom_range(0, 1));
            issa   = 5'($urandom_range(0, 7));
            flsh   = ($urandom_range(0, 15) == 0);
            ra[0]  = 5'($urandom_range(0, 7));
            ra[1]  = 5'($urandom_range(0, 7));
            cycle();
        end
        idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
